// File: rtl/multi_port_register_file.sv
// multi_port_register_file: 2-write/2-read register file with optional zero register,
// write-to-read bypass, registered reads and a one-register-per-cycle sequential clear.
module multi_port_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             writeEnable0,
    input  logic             writeEnable1,
    input  logic [DEPTH-1:0] writeAddr0,
    input  logic [DEPTH-1:0] writeAddr1,
    input  logic [WIDTH-1:0] writeData0,
    input  logic [WIDTH-1:0] writeData1,
    input  logic [DEPTH-1:0] readAddrA,
    input  logic [DEPTH-1:0] readAddrB,
    output logic [WIDTH-1:0] readDataA,
    output logic [WIDTH-1:0] readDataB,
    input  logic             clearReq,
    output logic             busy,
    output logic             clearDone
);
    typedef enum logic {IDLE, CLEARING} state_t;
    localparam int NREGS = 2**DEPTH;
    state_t state, state_next;
    logic [DEPTH-1:0] count;
    logic [WIDTH-1:0] regs [NREGS];
    logic we0, we1, done_next;
    logic [WIDTH-1:0] comb_a, comb_b;

    assign busy = state == CLEARING;
    // accepted writes: only in IDLE, and never to the hardwired zero register
    assign we0 = writeEnable0 && !busy && !(ZERO_REG != 0 && writeAddr0 == '0);
    assign we1 = writeEnable1 && !busy && !(ZERO_REG != 0 && writeAddr1 == '0);

    function automatic logic [WIDTH-1:0] read_port(input logic [DEPTH-1:0] addr);
        return (ZERO_REG != 0 && addr == '0) ? '0 :
               (BYPASS != 0 && we1 && writeAddr1 == addr) ? writeData1 :
               (BYPASS != 0 && we0 && writeAddr0 == addr) ? writeData0 : regs[addr];
    endfunction

    assign comb_a = read_port(readAddrA);
    assign comb_b = read_port(readAddrB);

    always_comb begin
        state_next = state == IDLE ? (clearReq ? CLEARING : IDLE) : (&count ? IDLE : CLEARING);
        done_next  = busy && &count;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            count     <= '0;
            clearDone <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= busy ? count + 1'b1 : '0;
            clearDone <= done_next;
        end
    end

    // port 1 is assigned last so it wins a same-address collision
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (busy) begin
            regs[count] <= '0;
        end else begin
            if (we0) regs[writeAddr0] <= writeData0;
            if (we1) regs[writeAddr1] <= writeData1;
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    readDataA <= '0;
                    readDataB <= '0;
                end else begin
                    readDataA <= comb_a;
                    readDataB <= comb_b;
                end
            end
        end else begin : g_comb
            assign readDataA = comb_a;
            assign readDataB = comb_b;
        end
    endgenerate
endmodule

// File: tb/tb_multi_port_register_file.sv
// tb_multi_port_register_file: directed vectors with a queue-based scoreboard against bypass and no-bypass instances
module tb_multi_port_register_file;
  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        writeEnable0, writeEnable1, clearReq;
  logic [4:0]  writeAddr0, writeAddr1, readAddrA, readAddrB;
  logic [31:0] writeData0, writeData1;
  logic [31:0] readDataA, readDataB, nb_readDataA, nb_readDataB;
  logic        busy, clearDone, nb_busy, nb_clearDone;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;
  item_t sb[$];
  int passed = 0;
  int total = 0;
  multi_port_register_file dut (
    .clk(clk), .resetN(resetN),
    .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
    .writeAddr0(writeAddr0), .writeAddr1(writeAddr1),
    .writeData0(writeData0), .writeData1(writeData1),
    .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(readDataA), .readDataB(readDataB),
    .clearReq(clearReq), .busy(busy), .clearDone(clearDone)
  );
  multi_port_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .resetN(resetN),
    .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
    .writeAddr0(writeAddr0), .writeAddr1(writeAddr1),
    .writeData0(writeData0), .writeData1(writeData1),
    .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(nb_readDataA), .readDataB(nb_readDataB),
    .clearReq(clearReq), .busy(nb_busy), .clearDone(nb_clearDone)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = e.sel == 0 ? readDataA : e.sel == 1 ? readDataB :
            e.sel == 2 ? nb_readDataA : e.sel == 3 ? nb_readDataB :
            e.sel == 4 ? {31'd0, busy} : {31'd0, clearDone};
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end
  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    item_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    writeEnable0 = e0; writeAddr0 = a0; writeData0 = d0;
    writeEnable1 = e1; writeAddr1 = a1; writeData1 = d1;
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    readAddrA = a;
    readAddrB = b;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    wr(0, 0, 0, 0, 0, 0);
    rd(5, 0);
    clearReq = 1'b0;
    #1 resetN = 1'b0;
    #1;
    total++;
    if (busy === 1'b0 && clearDone === 1'b0) passed++;
    else $display("FAIL rst_direct: busy %b clearDone %b", busy, clearDone);
    chk("rst_busy", 4, 0);
    chk("rst_done", 5, 0);
    chk("rst_rdA", 0, 0);
    chk("rst_rdB", 1, 0);
    cyc();
    cyc();
    resetN = 1'b1;
    cyc();
    wr(1, 5, 32'hDEADBEEF, 0, 0, 0);
    rd(6, 0);
    chk("wr_other_addr", 0, 0);
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    rd(5, 0);
    chk("rd_after_wr", 0, 32'hDEADBEEF);
    cyc();
    wr(1, 3, 32'h11, 1, 3, 32'h22);
    rd(3, 3);
    chk("collide_bypass", 0, 32'h22);
    chk("collide_nobypass", 3, 0);
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    chk("collide_stored", 0, 32'h22);
    chk("collide_stored_nb", 2, 32'h22);
    cyc();
    wr(1, 7, 32'h77, 0, 0, 0);
    cyc();
    wr(0, 0, 0, 1, 7, 32'hA5);
    rd(5, 7);
    chk("bypass_p1", 1, 32'hA5);
    chk("nobypass_old", 3, 32'h77);
    cyc();
    wr(1, 9, 32'h99, 0, 0, 0);
    rd(9, 7);
    chk("bypass_p0", 0, 32'h99);
    chk("nobypass_p0", 2, 0);
    chk("stored_7", 1, 32'hA5);
    chk("stored_7_nb", 3, 32'hA5);
    cyc();
    wr(1, 0, 32'hFFFF, 1, 0, 32'hFFFF);
    rd(0, 0);
    chk("zero_bypass", 0, 0);
    chk("zero_nobypass", 3, 0);
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    chk("zero_stored", 0, 0);
    chk("zero_stored_nb", 2, 0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      wr(1, 5'(2 * i), 32'h100 + 32'(2 * i), 1, 5'(2 * i + 1), 32'h101 + 32'(2 * i));
    end
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    rd(31, 1);
    chk("fill_31", 0, 32'h11F);
    chk("fill_1", 1, 32'h101);
    cyc();
    clearReq = 1'b1;
    rd(0, 16);
    chk("pre_clear_busy", 4, 0);
    chk("fill_0_zero", 0, 0);
    chk("fill_16", 1, 32'h110);
    for (int k = 0; k < 32; k++) begin
      cyc();
      wr(1, 31, 32'hDEAD, 1, 30, 32'hBEEF);
      rd(31, 30);
      chk($sformatf("clr_busy_%0d", k), 4, 1);
      chk($sformatf("clr_done_%0d", k), 5, 0);
      chk($sformatf("clr_rd31_%0d", k), 0, 32'h11F);
      chk($sformatf("clr_rd30_%0d", k), 1, k == 31 ? 32'h0 : 32'h11E);
    end
    cyc();
    clearReq = 1'b0;
    wr(0, 0, 0, 0, 0, 0);
    chk("clr_end_busy", 4, 0);
    chk("clr_end_done", 5, 1);
    chk("clr_end_rd31", 0, 0);
    chk("clr_end_rd30", 1, 0);
    cyc();
    chk("clr_done_once", 5, 0);
    chk("clr_idle_busy", 4, 0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      rd(5'(2 * i), 5'(2 * i + 1));
      chk($sformatf("cleared_%0d", 2 * i), 0, 0);
      chk($sformatf("cleared_%0d", 2 * i + 1), 1, 0);
      chk("cleared_done", 5, 0);
    end
    cyc();
    wr(1, 12, 32'hC, 1, 20, 32'h14);
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    rd(12, 20);
    clearReq = 1'b1;
    chk("refill_12", 0, 32'hC);
    chk("refill_20", 1, 32'h14);
    cyc();
    clearReq = 1'b0;
    chk("abort_busy_start", 4, 1);
    repeat (10) cyc();
    resetN = 1'b0;
    rd(20, 12);
    chk("abort_busy", 4, 0);
    chk("abort_done", 5, 0);
    chk("abort_rd20", 0, 0);
    chk("abort_rd12", 1, 0);
    cyc();
    resetN = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cyc();
      rd(5'(2 * i), 5'(2 * i + 1));
      chk("post_abort_busy", 4, 0);
      chk("post_abort_done", 5, 0);
      if (i < 16) begin
        chk($sformatf("post_abort_%0d", 2 * i), 0, 0);
        chk($sformatf("post_abort_%0d", 2 * i + 1), 1, 0);
      end
    end
    cyc();
    wr(1, 12, 32'h1234, 0, 0, 0);
    cyc();
    wr(0, 0, 0, 0, 0, 0);
    rd(12, 0);
    chk("wr_after_abort", 0, 32'h1234);
    cyc();
    @(negedge clk);
    #1;
    if (sb.size() != 0) $display("FAIL scoreboard: %0d checks not drained", sb.size());
    if (passed != total) $display("FAIL summary: %0d of %0d checks failed", total - passed, total);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
